// File: rtl/byte_arbiter.sv
// byte_arbiter: N-to-1 round-robin arbiter for the byte-masked memory port.
// Several initiators share one memory target. The grant is pinned to the
// current initiator while the memory holds, and read data is routed back
// to the initiator whose request was accepted in the previous cycle.
//
// Handshake: an initiator presents a request by raising useEnable_i and
// keeps every request field stable while useHold_o is high. The request is
// accepted in the first cycle where useEnable_i=1 and useHold_o=0. On the
// memory side the request is accepted when memEnable_o=1 and memHold_i=0.
// Read data returns exactly one cycle after accept, flagged by
// useReadValid_o. Writes produce no return.
module byte_arbiter #(
    parameter int USERS     = 2,
    parameter int DATA_BYTE = 4,
    parameter int ADDR_SIZE = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [USERS-1:0]                      useEnable_i,
    input  logic [USERS-1:0]                      useIsWrite_i,
    input  logic [USERS-1:0][DATA_BYTE-1:0]       useWriteMask_i,
    input  logic [USERS-1:0][ADDR_SIZE-1:0]       useAddr_i,
    input  logic [USERS-1:0][DATA_BYTE*8-1:0]     useWriteData_i,
    output logic [USERS-1:0][DATA_BYTE*8-1:0]     useReadData_o,
    output logic [USERS-1:0]                      useReadValid_o,
    output logic [USERS-1:0]                      useHold_o,
    output logic                                  memEnable_o,
    output logic                                  memIsWrite_o,
    output logic [DATA_BYTE-1:0]                  memWriteMask_o,
    output logic [ADDR_SIZE-1:0]                  memAddr_o,
    output logic [DATA_BYTE*8-1:0]                memWriteData_o,
    input  logic [DATA_BYTE*8-1:0]                memReadData_i,
    input  logic                                  memHold_i
);

    // Width of the grant index; at least one bit even for a single user.
    localparam int IDX_W = (USERS > 1) ? $clog2(USERS) : 1;
    localparam logic [IDX_W:0]   USERS_EXT = (IDX_W+1)'(USERS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(USERS - 1);

    // Arbitration state.
    logic [IDX_W-1:0] prio_r;     // first initiator searched on a fresh arbitration
    logic             lock_r;     // grant pinned because memory is holding
    logic [IDX_W-1:0] lockIdx_r;  // initiator the grant is pinned to
    logic             rdValid_r;  // read return due this cycle
    logic [IDX_W-1:0] rdOwner_r;  // initiator that owns the read return

    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] grant_next;
    logic [IDX_W:0]   cand;
    logic             found;
    logic             any_req;
    logic             accept;

    assign any_req    = |useEnable_i;
    assign accept     = any_req && !memHold_i;
    assign grant_next = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);

    // Grant select: a live lock wins; otherwise rotate from prio_r. A lock whose
    // owner dropped enable is ignored so a misbehaving initiator cannot stall others.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        if (lock_r && useEnable_i[lockIdx_r]) begin
            grant = lockIdx_r;
        end else begin
            for (int k = 0; k < USERS; k++) begin
                cand = {1'b0, prio_r} + (IDX_W+1)'(k);
                if (cand >= USERS_EXT) begin
                    cand = cand - USERS_EXT;
                end
                if (!found && useEnable_i[cand[IDX_W-1:0]]) begin
                    grant = cand[IDX_W-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    // Forward the granted initiator's request; the memory bus is all zero when idle.
    always_comb begin
        memEnable_o    = any_req;
        memIsWrite_o   = 1'b0;
        memWriteMask_o = '0;
        memAddr_o      = '0;
        memWriteData_o = '0;
        if (any_req) begin
            memIsWrite_o   = useIsWrite_i[grant];
            memWriteMask_o = useWriteMask_i[grant];
            memAddr_o      = useAddr_i[grant];
            memWriteData_o = useWriteData_i[grant];
        end
    end

    // Every requester except the granted one (when memory is not stalling) is held.
    always_comb begin
        useHold_o = '0;
        for (int i = 0; i < USERS; i++) begin
            useHold_o[i] = useEnable_i[i] && !((grant == IDX_W'(i)) && !memHold_i);
        end
    end

    // Steer the memory read data to the owner of the pending return only.
    always_comb begin
        useReadValid_o = '0;
        useReadData_o  = '0;
        for (int i = 0; i < USERS; i++) begin
            useReadValid_o[i] = rdValid_r && (rdOwner_r == IDX_W'(i));
            if (useReadValid_o[i]) begin
                useReadData_o[i] = memReadData_i;
            end
        end
    end

    // Advance priority on accept, pin the grant on a stall, track read returns.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prio_r    <= '0;
            lock_r    <= 1'b0;
            lockIdx_r <= '0;
            rdValid_r <= 1'b0;
            rdOwner_r <= '0;
        end else if (accept) begin
            prio_r    <= grant_next;
            lock_r    <= 1'b0;
            rdValid_r <= !memIsWrite_o;
            rdOwner_r <= grant;
        end else if (any_req) begin
            lock_r    <= 1'b1;
            lockIdx_r <= grant;
            rdValid_r <= 1'b0;
        end else begin
            lock_r    <= 1'b0;
            rdValid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_arbiter.sv
// Directed bench for byte_arbiter: a two-user instance covers read return,
// round-robin, hold locking, write/read pipelining and async reset; a
// three-user instance covers priority wrap-around.
module tb_byte_arbiter;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- two-user instance ----------------
    logic [1:0]        en, wr, rvalid, hold;
    logic [1:0][3:0]   mask;
    logic [1:0][31:0]  addr, wdata, rdata;
    logic              mem_en, mem_wr, mem_hold;
    logic [3:0]        mem_mask;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;

    byte_arbiter #(.USERS(2), .DATA_BYTE(4), .ADDR_SIZE(32)) u_dut2 (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .useEnable_i    (en),
        .useIsWrite_i   (wr),
        .useWriteMask_i (mask),
        .useAddr_i      (addr),
        .useWriteData_i (wdata),
        .useReadData_o  (rdata),
        .useReadValid_o (rvalid),
        .useHold_o      (hold),
        .memEnable_o    (mem_en),
        .memIsWrite_o   (mem_wr),
        .memWriteMask_o (mem_mask),
        .memAddr_o      (mem_addr),
        .memWriteData_o (mem_wdata),
        .memReadData_i  (mem_rdata),
        .memHold_i      (mem_hold)
    );

    // ---------------- three-user instance ----------------
    logic [2:0]        en3, wr3, rvalid3, hold3;
    logic [2:0][3:0]   mask3;
    logic [2:0][31:0]  addr3, wdata3, rdata3;
    logic              mem_en3, mem_wr3;
    logic [3:0]        mem_mask3;
    logic [31:0]       mem_addr3, mem_wdata3;

    byte_arbiter #(.USERS(3), .DATA_BYTE(4), .ADDR_SIZE(32)) u_dut3 (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .useEnable_i    (en3),
        .useIsWrite_i   (wr3),
        .useWriteMask_i (mask3),
        .useAddr_i      (addr3),
        .useWriteData_i (wdata3),
        .useReadData_o  (rdata3),
        .useReadValid_o (rvalid3),
        .useHold_o      (hold3),
        .memEnable_o    (mem_en3),
        .memIsWrite_o   (mem_wr3),
        .memWriteMask_o (mem_mask3),
        .memAddr_o      (mem_addr3),
        .memWriteData_o (mem_wdata3),
        .memReadData_i  (mem_rdata),
        .memHold_i      (mem_hold)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_bad    = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Outputs are observed on the falling edge.
    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle_all();
        en = '0; wr = '0; mask = '0; addr = '0; wdata = '0;
        en3 = '0; wr3 = '0; mask3 = '0; addr3 = '0; wdata3 = '0;
        mem_hold = 1'b0;
        mem_rdata = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] e;
        logic [31:0] prev;
        idle_all();

        // Reset state
        #2;
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_hold", hold, 2'b00);
        chk("rst_mem_en", mem_en, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Single read by user1
        next_cycle();
        en = 2'b10; addr[1] = 32'h10;
        sample();
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_mem_en", mem_en, 1'b1);
        chk("rd_mem_wr", mem_wr, 1'b0);
        chk("rd_hold", hold, 2'b00);
        next_cycle();
        en = 2'b00; mem_rdata = 32'hDEADBEEF;
        sample();
        chk("rd_rvalid", rvalid, 2'b10);
        chk("rd_rdata1", rdata[1], 32'hDEADBEEF);
        chk("rd_rdata0", rdata[0], 32'h0);
        chk("idle_mem_addr", mem_addr, 32'h0);
        next_cycle();
        sample();
        chk("rd_rvalid_done", rvalid, 2'b00);

        // Round-robin with both users reading continuously (priority is back at 0)
        addr[0] = 32'h100; addr[1] = 32'h200;
        exp_q = {32'h100, 32'h200, 32'h100, 32'h200};
        prev = '0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            en = 2'b11; mem_rdata = 32'h5000 + 32'(c);
            sample();
            e = exp_q.pop_front();
            chk("rr_addr", mem_addr, e);
            chk("rr_hold", hold, (e == 32'h100) ? 2'b10 : 2'b01);
            if (c == 0) chk("rr_rvalid", rvalid, 2'b00);
            else        chk("rr_rvalid", rvalid, (prev == 32'h100) ? 2'b01 : 2'b10);
            prev = e;
        end
        next_cycle();
        en = 2'b00;
        sample();
        chk("rr_last_rvalid", rvalid, 2'b10);

        // Lock under hold: user0 accepted once so priority points at user1
        next_cycle();
        en = 2'b01;
        sample();
        chk("lk_pre_addr", mem_addr, 32'h100);
        next_cycle();
        mem_hold = 1'b1; mem_rdata = 32'h11112222;
        sample();
        chk("lk0_addr", mem_addr, 32'h100);
        chk("lk0_hold", hold, 2'b01);
        chk("lk0_rvalid", rvalid, 2'b01);
        chk("lk0_rdata0", rdata[0], 32'h11112222);
        for (int c = 1; c < 3; c++) begin
            next_cycle();
            en = 2'b11;
            sample();
            chk("lk_addr", mem_addr, 32'h100);
            chk("lk_hold", hold, 2'b11);
            chk("lk_rvalid", rvalid, 2'b00);
        end
        next_cycle();
        mem_hold = 1'b0;
        sample();
        chk("lk3_addr", mem_addr, 32'h100);
        chk("lk3_hold", hold, 2'b10);
        next_cycle();
        sample();
        chk("lk4_addr", mem_addr, 32'h200);
        chk("lk4_hold", hold, 2'b01);
        chk("lk4_rvalid", rvalid, 2'b01);
        next_cycle();
        en = 2'b00;
        sample();
        chk("lk5_rvalid", rvalid, 2'b10);

        // Write by user0 then read by user1
        next_cycle();
        en = 2'b01; wr = 2'b01; mask[0] = 4'b0001; wdata[0] = 32'hAB; addr[0] = 32'h40;
        sample();
        chk("wr_mem_wr", mem_wr, 1'b1);
        chk("wr_mask", mem_mask, 4'b0001);
        chk("wr_wdata", mem_wdata, 32'hAB);
        chk("wr_addr", mem_addr, 32'h40);
        chk("wr_hold", hold, 2'b00);
        next_cycle();
        en = 2'b10; wr = 2'b00; mask[0] = 4'b0000; wdata[0] = '0; addr[1] = 32'h44;
        sample();
        chk("wr_no_ret", rvalid, 2'b00);
        chk("rd2_mem_wr", mem_wr, 1'b0);
        chk("rd2_addr", mem_addr, 32'h44);
        next_cycle();
        en = 2'b00; mem_rdata = 32'hCAFEF00D;
        sample();
        chk("rd2_rvalid", rvalid, 2'b10);
        chk("rd2_rdata1", rdata[1], 32'hCAFEF00D);

        // Async reset between user0's read accept and its return
        next_cycle();
        en = 2'b01; addr[0] = 32'h100;
        sample();
        chk("ar_addr", mem_addr, 32'h100);
        next_cycle();
        en = 2'b00; mem_rdata = 32'h77778888;
        #1;
        chk("ar_pre_rvalid", rvalid, 2'b01);
        rst_i = 1'b0;
        #1;
        chk("ar_rvalid", rvalid, 2'b00);
        chk("ar_rdata0", rdata[0], 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        next_cycle();
        en = 2'b11; addr[1] = 32'h200;
        sample();
        chk("ar_prio0_addr", mem_addr, 32'h100);
        chk("ar_no_stale", rvalid, 2'b00);
        next_cycle();
        en = 2'b00;

        // Three users: user2 alone, then users 0 and 2 -> priority wraps to 0
        next_cycle();
        en3 = 3'b100; addr3[2] = 32'h300; addr3[0] = 32'h30;
        sample();
        chk("w3_addr", mem_addr3, 32'h300);
        chk("w3_hold", hold3, 3'b000);
        next_cycle();
        en3 = 3'b101; mem_rdata = 32'h0BADF00D;
        sample();
        chk("w3_wrap_addr", mem_addr3, 32'h30);
        chk("w3_wrap_hold", hold3, 3'b100);
        chk("w3_rvalid", rvalid3, 3'b100);
        chk("w3_rdata2", rdata3[2], 32'h0BADF00D);
        next_cycle();
        en3 = 3'b100;
        sample();
        chk("w3_next_addr", mem_addr3, 32'h300);
        chk("w3_rvalid0", rvalid3, 3'b001);
        next_cycle();
        en3 = 3'b000;

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
